// File: rtl/matrix_pkg.sv
// Shared types and sizing helpers for the 8x8 LED matrix scan driver.
package matrix_pkg;

    localparam int MATRIX_ROWS = 8;
    localparam int MATRIX_COLS = 8;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    typedef logic [MATRIX_COLS-1:0] row_t;

    // Counter width able to hold max(a,b)-1, never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Dwell/blanking timer: up-counter that reloads to zero on load and flags its last count.
module scan_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] count_next,
    output logic             done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: restart at zero whenever the owner changes phase.
    always_comb begin
        if (load) begin
            count_d = '0;
        end else begin
            count_d = count_q + WIDTH'(1);
        end
    end

    assign count_next = count_d;
    assign done       = (count_q == last);

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/matrix_scan.sv
// Frame buffer plus row-multiplexed scan driver for the 8x8 LED matrix.
// Define MATRIX_SCAN_SHADOW_EN for a double-buffered, tear-free frame.
module matrix_scan #(
    parameter int SCAN_DIV  = 1024,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       write_strobe,
    input  logic [2:0] row_index,
    input  logic [7:0] row_val,
    input  logic       clr_array,
    output logic [7:0] row_sel,
    output logic [7:0] col_data,
    output logic       frame_done
);

    import matrix_pkg::*;

    localparam int               CNT_W      = cnt_width(SCAN_DIV, BLANK_CYC);
    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam row_t             ROW_ONE    = 8'h01;

    scan_state_t      state_q;
    scan_state_t      state_d;
    logic [2:0]       scan_row_q;
    logic [2:0]       scan_row_d;
    row_t             row_sel_q;
    row_t             row_sel_d;
    row_t             col_data_q;
    row_t             col_data_d;
    logic             frame_done_q;
    logic             frame_done_d;
    row_t             front_q [MATRIX_ROWS];
    row_t             front_d [MATRIX_ROWS];
    logic [CNT_W-1:0] timer_last_s;
    logic [CNT_W-1:0] count_next_s;
    logic             timer_done_s;

    // The timer reloads exactly when the FSM leaves its current phase.
    scan_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_done_s),
        .last       (timer_last_s),
        .count_next (count_next_s),
        .done       (timer_done_s)
    );

    // Phase sequencing: BLANK -> DRIVE -> next row's BLANK.
    always_comb begin
        state_d      = state_q;
        scan_row_d   = scan_row_q;
        timer_last_s = BLANK_LAST;
        case (state_q)
            BLANK: begin
                timer_last_s = BLANK_LAST;
                if (timer_done_s) begin
                    state_d = DRIVE;
                end else begin
                    state_d = BLANK;
                end
            end
            DRIVE: begin
                timer_last_s = SCAN_LAST;
                if (timer_done_s) begin
                    state_d    = BLANK;
                    scan_row_d = scan_row_q + 3'd1;
                end else begin
                    state_d    = DRIVE;
                    scan_row_d = scan_row_q;
                end
            end
            default: begin
                state_d    = BLANK;
                scan_row_d = 3'd0;
            end
        endcase
    end

    // Outputs are decoded from the next phase so the registers line up with it.
    always_comb begin
        if (state_d == DRIVE) begin
            row_sel_d    = ROW_ONE << scan_row_d;
            col_data_d   = front_q[scan_row_d];
            frame_done_d = (scan_row_d == 3'd7) && (count_next_s == SCAN_LAST);
        end else begin
            row_sel_d    = 8'h00;
            col_data_d   = 8'h00;
            frame_done_d = 1'b0;
        end
    end

`ifdef MATRIX_SCAN_SHADOW_EN
    row_t back_q [MATRIX_ROWS];
    row_t back_d [MATRIX_ROWS];

    // Writes land in the back buffer; the copy uses its pre-edge contents.
    always_comb begin
        back_d  = back_q;
        front_d = front_q;
        if (clr_array) begin
            back_d  = '{default: '0};
            front_d = '{default: '0};
        end else begin
            if (frame_done_q) begin
                front_d = back_q;
            end else begin
                front_d = front_q;
            end
            if (write_strobe) begin
                back_d[row_index] = row_val;
            end else begin
                back_d = back_q;
            end
        end
    end

    // Back buffer storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            back_q <= '{default: '0};
        end else begin
            back_q <= back_d;
        end
    end
`else
    // Single buffer: clear wins over a simultaneous write.
    always_comb begin
        front_d = front_q;
        if (clr_array) begin
            front_d = '{default: '0};
        end else if (write_strobe) begin
            front_d[row_index] = row_val;
        end else begin
            front_d = front_q;
        end
    end
`endif

    // Scan state, displayed buffer and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= BLANK;
            scan_row_q   <= 3'd0;
            row_sel_q    <= 8'h00;
            col_data_q   <= 8'h00;
            frame_done_q <= 1'b0;
            front_q      <= '{default: '0};
        end else begin
            state_q      <= state_d;
            scan_row_q   <= scan_row_d;
            row_sel_q    <= row_sel_d;
            col_data_q   <= col_data_d;
            frame_done_q <= frame_done_d;
            front_q      <= front_d;
        end
    end

    assign row_sel    = row_sel_q;
    assign col_data   = col_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_matrix_scan.sv
// Self-checking bench for matrix_scan with SCAN_DIV=4, BLANK_CYC=2 (48-cycle frame).
module tb_matrix_scan;

    localparam int SD = 4;
    localparam int BC = 2;
    localparam int RP = SD + BC;
    localparam int FP = 8 * RP;

    logic       clk = 1'b0;
    logic       reset;
    logic       write_strobe;
    logic [2:0] row_index;
    logic [7:0] row_val;
    logic       clr_array;
    logic [7:0] row_sel;
    logic [7:0] col_data;
    logic       frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycles since reset release and buffer contents.
    int         cyc;
    logic [7:0] m_back  [8];
    logic [7:0] m_front [8];
    logic [7:0] m_vis   [8];

    typedef struct {
        int         at;
        logic [7:0] sel;
        logic [7:0] col;
        logic       fd;
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;

    matrix_scan #(
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write_strobe (write_strobe),
        .row_index    (row_index),
        .row_val      (row_val),
        .clr_array    (clr_array),
        .row_sel      (row_sel),
        .col_data     (col_data),
        .frame_done   (frame_done)
    );

    function automatic logic [7:0] exp_sel(input int k);
        int         pos;
        logic [7:0] one;
        pos = k % FP;
        one = 8'h01;
        return ((pos % RP) >= BC) ? (one << (pos / RP)) : 8'h00;
    endfunction

    function automatic logic exp_fd(input int k);
        return (k % FP) == (FP - 1);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_model();
        logic [7:0] ecol;
        ecol = (exp_sel(cyc) != 8'h00) ? m_vis[(cyc % FP) / RP] : 8'h00;
        check("row_sel", row_sel, exp_sel(cyc));
        check("col_data", col_data, ecol);
        check("frame_done", {7'd0, frame_done}, {7'd0, exp_fd(cyc)});
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            m_back[i]  = 8'h00;
            m_front[i] = 8'h00;
            m_vis[i]   = 8'h00;
        end
    endtask

    task automatic model_edge(input logic we, input logic [2:0] idx, input logic [7:0] val,
                              input logic clr);
        int prev_pos;
        m_vis    = m_front;
        prev_pos = cyc % FP;
        cyc++;
        if (clr) begin
            for (int i = 0; i < 8; i++) begin
                m_back[i]  = 8'h00;
                m_front[i] = 8'h00;
            end
        end else begin
`ifdef MATRIX_SCAN_SHADOW_EN
            if (prev_pos == FP - 1) m_front = m_back;
            if (we) m_back[idx] = val;
`else
            if (we) begin
                m_back[idx]  = val;
                m_front[idx] = val;
            end
`endif
        end
    endtask

    task automatic step(input logic we, input logic [2:0] idx, input logic [7:0] val,
                        input logic clr);
        write_strobe = we;
        row_index    = idx;
        row_val      = val;
        clr_array    = clr;
        @(posedge clk);
        model_edge(we, idx, val, clr);
        #1;
        check_model();
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 8'h00, 1'b0);
    endtask

    task automatic advance_to(input int p);
        do idle(); while ((cyc % FP) != p);
    endtask

    initial begin
        reset        = 1'b0;
        write_strobe = 1'b0;
        row_index    = 3'd0;
        row_val      = 8'h00;
        clr_array    = 1'b0;
        model_reset();

        tbl[0]  = '{0,  8'h00, 8'h00, 1'b0};
        tbl[1]  = '{1,  8'h00, 8'h00, 1'b0};
        tbl[2]  = '{2,  8'h01, 8'h00, 1'b0};
        tbl[3]  = '{5,  8'h01, 8'h00, 1'b0};
        tbl[4]  = '{6,  8'h00, 8'h00, 1'b0};
        tbl[5]  = '{8,  8'h02, 8'h00, 1'b0};
        tbl[6]  = '{14, 8'h04, 8'h00, 1'b0};
        tbl[7]  = '{44, 8'h80, 8'h00, 1'b0};
        tbl[8]  = '{47, 8'h80, 8'h00, 1'b1};
        tbl[9]  = '{48, 8'h00, 8'h00, 1'b0};
        tbl[10] = '{50, 8'h01, 8'h00, 1'b0};
        tbl[11] = '{95, 8'h80, 8'h00, 1'b1};

        #1;
        check("rst_row_sel", row_sel, 8'h00);
        check("rst_col_data", col_data, 8'h00);
        check("rst_frame_done", {7'd0, frame_done}, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Free-run scan pattern against fixed vectors.
        for (int i = 0; i < 12; i++) begin
            while (cyc < tbl[i].at) idle();
            check("tbl_row_sel", row_sel, tbl[i].sel);
            check("tbl_col_data", col_data, tbl[i].col);
            check("tbl_frame_done", {7'd0, frame_done}, {7'd0, tbl[i].fd});
        end

        // Row 3 = E0 and row 0 = FF shown in their own rows, blank elsewhere.
        step(1'b1, 3'd3, 8'hE0, 1'b0);
        step(1'b1, 3'd0, 8'hFF, 1'b0);
        repeat (FP) idle();
        advance_to(2);
        check("row0_ff", col_data, 8'hFF);
        advance_to(18);
        check("row3_blank", col_data, 8'h00);
        advance_to(20);
        check("row3_e0", col_data, 8'hE0);

        // Mid-dwell write to row 2 while it is being driven.
        advance_to(14);
        step(1'b1, 3'd2, 8'h1C, 1'b0);
        check("row2_mid_lat1", col_data, 8'h00);
        idle();
`ifdef MATRIX_SCAN_SHADOW_EN
        check("row2_mid_lat2", col_data, 8'h00);
`else
        check("row2_mid_lat2", col_data, 8'h1C);
`endif

`ifdef MATRIX_SCAN_SHADOW_EN
        // Shadow: mid-frame write waits for the copy; copy-edge write waits a frame.
        repeat (FP) idle();
        advance_to(4);
        step(1'b1, 3'd1, 8'h3C, 1'b0);
        advance_to(8);
        check("shadow_old", col_data, 8'h00);
        advance_to(8);
        check("shadow_new", col_data, 8'h3C);
        advance_to(47);
        step(1'b1, 3'd1, 8'hC3, 1'b0);
        advance_to(8);
        check("shadow_copy_edge_old", col_data, 8'h3C);
        advance_to(8);
        check("shadow_copy_edge_new", col_data, 8'hC3);
`endif

        // Clear beats a simultaneous write; next frame is all dark.
        advance_to(10);
        step(1'b1, 3'd5, 8'hAA, 1'b1);
        advance_to(0);
        for (int i = 0; i < FP; i++) begin
            idle();
            check("clr_dark", col_data, 8'h00);
        end

        // Randomized writes and occasional clears against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 255)), ($urandom_range(0, 31) == 0));
        end

        // Asynchronous reset during row 6 drive.
        step(1'b1, 3'd6, 8'h5A, 1'b0);
        repeat (FP) idle();
        advance_to(39);
        check("row6_before_rst", col_data, 8'h5A);
        #2;
        reset = 1'b0;
        #1;
        check("async_row_sel", row_sel, 8'h00);
        check("async_col_data", col_data, 8'h00);
        check("async_frame_done", {7'd0, frame_done}, 8'h00);
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        check("rel_row_sel", row_sel, 8'h00);
        idle();
        idle();
        check("restart_row0", row_sel, 8'h01);
        repeat (FP) idle();
        advance_to(38);
        check("row6_after_rst", col_data, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_scan.md
# matrix_scan

Frame buffer and row-multiplexed scan driver for the 8x8 LED matrix. Sits directly downstream of the game state machine. It captures each row write (`write_strobe`, `row_index`, `row_val`) into an 8-row buffer and clears the buffer on `clr_array`. It continuously drives the matrix one row at a time, with a blanking gap between rows to suppress ghosting.

## Interface
- `SCAN_DIV`, 1024, clk cycles each row is driven (≥1)
- `BLANK_CYC`, 16, clk cycles of blanking before each row (≥1)
- `clk` input 1 system clock, all logic on rising edge
- `reset` input 1 asynchronous, active-low reset
- `write_strobe` input 1 on a high cycle, write `row_val` into row `row_index`
- `row_index` input 3 target row, 0 = bottom row
- `row_val` input 8 row pixel pattern, bit 7 = leftmost column
- `clr_array` input 1 level, clears the whole buffer on every cycle it is high
- `row_sel` output 8 one-hot active-high row enable, all-zero while blanking
- `col_data` output 8 active-high column data for the selected row
- `frame_done` output 1 one-cycle pulse at the end of each full scan

## Operation
- Buffer is 8 rows × 8 bits.
- A write updates `buf[row_index]` at the clock edge where `write_strobe`=1.
- `clr_array`=1 zeroes all rows at the next edge. Clear has priority over a simultaneous write, so the write is lost.
- Scan FSM has two states:
  - BLANK: `row_sel`=0 and `col_data`=0 for `BLANK_CYC` cycles, then go to DRIVE.
  - DRIVE: `row_sel`=1<<`scan_row` and `col_data`=`front[scan_row]` for `SCAN_DIV` cycles. Then `scan_row` increments (7 wraps to 0) and the FSM returns to BLANK.
- `row_sel` and `col_data` are registered. During DRIVE, `col_data` resamples the buffer every cycle.
- `frame_done`=1 on the final DRIVE cycle of row 7.
- `clr_array` does not disturb the scan FSM, `scan_row`, or the counters.
- Reset values:
  - `row_sel`=0, `col_data`=0, `frame_done`=0.
  - FSM=BLANK, `scan_row`=0, cycle counter=0.
  - All buffer rows = 0.
- Deasserting reset mid-scan restarts from BLANK, row 0.

## Timing
- Write at edge t: buffer holds the new value after t. If that row is in DRIVE, `col_data` shows it after edge t+1 (2-cycle latency, no shadow).
- Frame period is exactly 8·(`BLANK_CYC`+`SCAN_DIV`) cycles. `frame_done` repeats at that period starting from the first frame after reset.
- Cycle counter width is $clog2(max(`SCAN_DIV`,`BLANK_CYC`)). It counts 0..N-1 and reloads 0 on every state change.
- Back-to-back writes, one per cycle, are all accepted. There is no backpressure.
- A write to the row currently in DRIVE takes effect mid-dwell, with no glitch beyond the 1-cycle update.

## Configuration
- Macro: `MATRIX_SCAN_SHADOW_EN`.
- Defined:
  - Writes go to a back buffer.
  - The back buffer is copied to the front buffer on the edge ending the `frame_done` cycle.
  - Scan reads only the front buffer, so a frame never tears.
  - A write on the copy edge lands in the back buffer only and appears in the following frame.
  - `clr_array` zeroes both buffers immediately.
- Undefined:
  - There is a single buffer, and the front buffer is the buffer itself.
  - Writes are visible with the 2-cycle latency above.

## Structure
- Package `matrix_pkg` holds:
  - `MATRIX_ROWS`=8 and `MATRIX_COLS`=8.
  - The `scan_state_t` enum {BLANK, DRIVE}.
  - The `row_t` typedef (logic [7:0]).
- Sub-module `scan_timer`:
  - Parameterized up-counter with a `load` input and a `done` output that goes high at count N-1.
  - Instantiated once. The FSM selects the limit: `BLANK_CYC` or `SCAN_DIV`.
- Buffer, write/clear logic and the shadow copy live in `matrix_scan`.

## Test plan
Run with `SCAN_DIV`=4 and `BLANK_CYC`=2. Frame period = 48 cycles.

- Reset, then free run → `row_sel` sequence 0,0,01,01,01,01,0,0,02,… through 80. `frame_done` high at cycles 47, 95, …. `col_data`=0 throughout.
- Write row 3=0xE0, then row 0=0xFF → during row 3 DRIVE `col_data`=0xE0. During row 0 DRIVE `col_data`=0xFF. `col_data`=0 during BLANK.
- Write row 2=0x1C while row 2 is in DRIVE, without shadow → `col_data` changes to 0x1C two cycles after the strobe.
- `clr_array` and `write_strobe` (row 5=0xAA) in the same cycle → all rows read 0 in the next frame.
- With `MATRIX_SCAN_SHADOW_EN` defined, write row 1=0x3C mid-frame → row 1 shows the old value until after the next `frame_done`, then shows 0x3C. A write on the copy edge appears one frame later.
- Assert `reset` during DRIVE of row 6 → outputs go to 0 immediately (asynchronously). After release, scanning restarts at BLANK, row 0, and the buffer reads 0.
